// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard / control unit.
package pipe_ctrl_pkg;

  // Forwarding mux selects for the E-stage SrcA/SrcB operands
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // ResultSrcE value that marks a load in E
  localparam logic [1:0] RES_LOAD = 2'b01;

  // Data-memory wait sequencer states
  typedef enum logic [1:0] {
    RUN     = 2'b00,
    WAIT    = 2'b01,
    RELEASE = 2'b10
  } mem_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward-select comparator for one E-stage source operand.
// M has priority over W; x0 is never forwarded.
module hazard_fwd_sel
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output logic [1:0]        fwd_sel
);

  logic hit_m;
  logic hit_w;

  // Compare the source against the M and W destinations, M wins
  always_comb begin
    hit_m = reg_write_m && (rd_m != '0) && (rd_m == rs_e);
    hit_w = reg_write_w && (rd_w != '0) && (rd_w == rs_e);
    if (hit_m) begin
      fwd_sel = FWD_M;
    end else if (hit_w) begin
      fwd_sel = FWD_W;
    end else begin
      fwd_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage core: operand forwarding,
// load-use stall, branch flush, data-memory wait sequencing and saturating
// stall/flush performance counters.
//
// state   | meaning
// --------+----------------------------------------------------------------
// RUN     | normal flow; a valid memory access in M starts a wait
// WAIT    | memory access outstanding, whole pipeline frozen
// RELEASE | access done, pipeline advances one cycle, MemValidM ignored
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [1:0]        ResultSrcE,
  input  logic              PCSrcE,
  input  logic              MemValidM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              StallW,
  output logic              FlushD,
  output logic              FlushE,
  output logic [CNT_W-1:0]  StallCycles,
  output logic [CNT_W-1:0]  FlushCount
);

  localparam bit MEM_EN   = (MEM_LAT > 0);
  // wait_cnt holds at most MEM_LAT-1
  localparam int WCW      = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
  localparam int LOAD_VAL = MEM_EN ? (MEM_LAT - 1) : 0;

  mem_state_e       state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_stall;
  logic lw_stall;
  logic lw_act;
  logic br_act;
  logic ld_hold;

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_e        (Rs1E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd_sel     (ForwardAE)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_e        (Rs2E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd_sel     (ForwardBE)
  );

  // Memory-wait sequencer: next state, wait counter and the freeze request.
  // wait_cnt is loaded with MEM_LAT-1 so the RUN cycle plus the WAIT cycles
  // add up to exactly MEM_LAT frozen cycles per access.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_stall  = 1'b0;
    case (state_q)
      RUN: begin
        if (MEM_EN && MemValidM) begin
          mem_stall  = 1'b1;
          wait_cnt_d = WCW'(LOAD_VAL);
          state_d    = (MEM_LAT == 1) ? RELEASE : WAIT;
        end
      end
      WAIT: begin
        mem_stall = 1'b1;
        if (wait_cnt_q <= WCW'(1)) begin
          wait_cnt_d = '0;
          state_d    = RELEASE;
        end else begin
          wait_cnt_d = wait_cnt_q - WCW'(1);
        end
      end
      RELEASE: begin
        state_d = RUN;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Load-use and branch hazards; both are masked while memory freezes the pipe
  always_comb begin
    lw_stall = (ResultSrcE == RES_LOAD) && (RdE != '0) &&
               ((RdE == Rs1D) || (RdE == Rs2D));
    lw_act   = lw_stall && !mem_stall;
    br_act   = PCSrcE && !mem_stall;
    // a taken branch makes the D instruction wrong-path, so no need to hold it
    ld_hold  = lw_act && !br_act;

    StallF = mem_stall || ld_hold;
    StallD = mem_stall || ld_hold;
    StallE = mem_stall;
    StallM = mem_stall;
    StallW = mem_stall;
    FlushD = br_act;
    FlushE = br_act || lw_act;
  end

  // Saturating performance counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((mem_stall || ld_hold) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (FlushD && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCycles = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: main MEM_LAT=2 instance, a
// MEM_LAT=0 instance and a narrow-counter instance sharing the same inputs.
module tb_pipe_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0;
  logic [4:0] RdE = '0, RdM = '0, RdW = '0;
  logic       RegWriteM = 1'b0, RegWriteW = 1'b0;
  logic [1:0] ResultSrcE = '0;
  logic       PCSrcE = 1'b0, MemValidM = 1'b0;

  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
  logic [15:0] StallCycles, FlushCount;

  logic [1:0]  l0_fa, l0_fb;
  logic        l0_sf, l0_sd, l0_se, l0_sm, l0_sw, l0_fd, l0_fe;
  logic [15:0] l0_sc, l0_fc;

  logic [1:0]  st_fa, st_fb;
  logic        st_sf, st_sd, st_se, st_sm, st_sw, st_fd, st_fe;
  logic [3:0]  st_sc, st_fc;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(.REG_AW(5), .MEM_LAT(2), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemValidM(MemValidM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  pipe_hazard_ctrl #(.REG_AW(5), .MEM_LAT(0), .CNT_W(16)) dut_lat0 (
    .CLK(CLK), .RST(RST), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemValidM(MemValidM),
    .ForwardAE(l0_fa), .ForwardBE(l0_fb),
    .StallF(l0_sf), .StallD(l0_sd), .StallE(l0_se), .StallM(l0_sm), .StallW(l0_sw),
    .FlushD(l0_fd), .FlushE(l0_fe), .StallCycles(l0_sc), .FlushCount(l0_fc)
  );

  pipe_hazard_ctrl #(.REG_AW(5), .MEM_LAT(20), .CNT_W(4)) dut_sat (
    .CLK(CLK), .RST(RST), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemValidM(MemValidM),
    .ForwardAE(st_fa), .ForwardBE(st_fb),
    .StallF(st_sf), .StallD(st_sd), .StallE(st_se), .StallM(st_sm), .StallW(st_sw),
    .FlushD(st_fd), .FlushE(st_fe), .StallCycles(st_sc), .FlushCount(st_fc)
  );

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       sf, sd, se, sm, sw, fd, fe;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int exp_stall_cnt = 0;
  int exp_flush_cnt = 0;
  int exp_sat = 0;
  bit sat_on = 1'b0;
  bit sat_stall_exp = 1'b0;
  bit lat0_on = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] fa, input logic [1:0] fb,
                              input logic mem, input logic hold,
                              input logic fd, input logic fe);
    exp_t e;
    e.fa = fa; e.fb = fb;
    e.sf = mem | hold; e.sd = mem | hold;
    e.se = mem; e.sm = mem; e.sw = mem;
    e.fd = fd; e.fe = fe;
    return e;
  endfunction

  task automatic clear_in();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    ResultSrcE = '0; PCSrcE = 1'b0; MemValidM = 1'b0;
  endtask

  // Push expectation for the inputs just driven, then pop and compare mid-cycle
  task automatic drive_check(input exp_t e);
    exp_t got;
    exp_q.push_back(e);
    @(negedge CLK);
    got = exp_q.pop_front();
    check_eq("fwd_a",     32'(ForwardAE), 32'(got.fa));
    check_eq("fwd_b",     32'(ForwardBE), 32'(got.fb));
    check_eq("stall_f",   32'(StallF),    32'(got.sf));
    check_eq("stall_d",   32'(StallD),    32'(got.sd));
    check_eq("stall_e",   32'(StallE),    32'(got.se));
    check_eq("stall_m",   32'(StallM),    32'(got.sm));
    check_eq("stall_w",   32'(StallW),    32'(got.sw));
    check_eq("flush_d",   32'(FlushD),    32'(got.fd));
    check_eq("flush_e",   32'(FlushE),    32'(got.fe));
    check_eq("stall_cnt", 32'(StallCycles), 32'(exp_stall_cnt));
    check_eq("flush_cnt", 32'(FlushCount),  32'(exp_flush_cnt));
    if (sat_on) begin
      check_eq("sat_cnt", 32'(st_sc), 32'(exp_sat));
      if (sat_stall_exp && exp_sat < 15) exp_sat++;
    end
    if (lat0_on) begin
      check_eq("lat0_stall_f", 32'(l0_sf), 32'd0);
      check_eq("lat0_stall_e", 32'(l0_se), 32'd0);
    end
    if (got.sf) exp_stall_cnt++;
    if (got.fd) exp_flush_cnt++;
    @(posedge CLK);
    if (!RST) begin
      exp_stall_cnt = 0;
      exp_flush_cnt = 0;
      exp_sat = 0;
    end
    #1;
  endtask

  initial begin
    clear_in();
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;

    // reset state with idle inputs
    drive_check(mk(2'b00, 2'b00, 0, 0, 0, 0));

    // forwarding: M wins over W
    RegWriteM = 1; RdM = 5; Rs1E = 5; RegWriteW = 1; RdW = 5;
    drive_check(mk(2'b10, 2'b00, 0, 0, 0, 0));
    // x0 in M is not forwarded, falls to W
    RdM = 0;
    drive_check(mk(2'b01, 2'b00, 0, 0, 0, 0));
    // x0 in W and source x0
    Rs1E = 0; Rs2E = 0; RdW = 0;
    drive_check(mk(2'b00, 2'b00, 0, 0, 0, 0));
    // both operands, different sources
    RdM = 3; Rs1E = 3; RdW = 9; Rs2E = 9;
    drive_check(mk(2'b10, 2'b01, 0, 0, 0, 0));
    // write enables gate forwarding
    RegWriteM = 0; RegWriteW = 0;
    drive_check(mk(2'b00, 2'b00, 0, 0, 0, 0));
    clear_in();

    // load-use: one bubble
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    drive_check(mk(2'b00, 2'b00, 0, 1, 0, 1));
    clear_in();
    drive_check(mk(2'b00, 2'b00, 0, 0, 0, 0));
    // no load-use when the load targets x0 or is not a load
    ResultSrcE = 2'b01; RdE = 0; Rs1D = 0;
    drive_check(mk(2'b00, 2'b00, 0, 0, 0, 0));
    ResultSrcE = 2'b00; RdE = 7; Rs1D = 7;
    drive_check(mk(2'b00, 2'b00, 0, 0, 0, 0));
    // load-use together with taken branch: flush wins
    ResultSrcE = 2'b01; RdE = 7; Rs1D = 7; PCSrcE = 1;
    drive_check(mk(2'b00, 2'b00, 0, 0, 1, 1));
    clear_in();
    // branch alone
    PCSrcE = 1;
    drive_check(mk(2'b00, 2'b00, 0, 0, 1, 1));
    clear_in();
    drive_check(mk(2'b00, 2'b00, 0, 0, 0, 0));

    // two back-to-back accesses, MEM_LAT=2
    MemValidM = 1;
    drive_check(mk(2'b00, 2'b00, 1, 0, 0, 0));
    drive_check(mk(2'b00, 2'b00, 1, 0, 0, 0));
    drive_check(mk(2'b00, 2'b00, 0, 0, 0, 0));
    drive_check(mk(2'b00, 2'b00, 1, 0, 0, 0));
    drive_check(mk(2'b00, 2'b00, 1, 0, 0, 0));
    MemValidM = 0;
    drive_check(mk(2'b00, 2'b00, 0, 0, 0, 0));
    drive_check(mk(2'b00, 2'b00, 0, 0, 0, 0));

    // branch masked during the wait, acts on release
    MemValidM = 1;
    drive_check(mk(2'b00, 2'b00, 1, 0, 0, 0));
    MemValidM = 0; PCSrcE = 1;
    drive_check(mk(2'b00, 2'b00, 1, 0, 0, 0));
    drive_check(mk(2'b00, 2'b00, 0, 0, 1, 1));
    clear_in();
    drive_check(mk(2'b00, 2'b00, 0, 0, 0, 0));

    // load-use masked during the wait; MemValidM ignored on release
    MemValidM = 1; ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
    drive_check(mk(2'b00, 2'b00, 1, 0, 0, 0));
    MemValidM = 0;
    drive_check(mk(2'b00, 2'b00, 1, 0, 0, 0));
    MemValidM = 1;
    drive_check(mk(2'b00, 2'b00, 0, 1, 0, 1));
    clear_in();
    drive_check(mk(2'b00, 2'b00, 0, 0, 0, 0));

    // reset in the middle of a wait
    MemValidM = 1;
    drive_check(mk(2'b00, 2'b00, 1, 0, 0, 0));
    MemValidM = 0; RST = 0;
    drive_check(mk(2'b00, 2'b00, 1, 0, 0, 0));
    RST = 1;
    drive_check(mk(2'b00, 2'b00, 0, 0, 0, 0));

    // held access stream: main stalls 2 of every 3 cycles, MEM_LAT=0 never
    // stalls, 4-bit counter of the MEM_LAT=20 copy saturates at 15
    sat_on = 1'b1;
    lat0_on = 1'b1;
    MemValidM = 1;
    for (int i = 0; i < 24; i++) begin
      sat_stall_exp = (i != 20);
      drive_check(mk(2'b00, 2'b00, (i % 3) != 2, 0, 0, 0));
    end
    sat_on = 1'b0;
    lat0_on = 1'b0;
    clear_in();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and pipeline-control unit for the 5-stage RISC-V core (F/D/E/M/W).
- Generates the E-stage operand forwarding selects, per-stage stall and flush enables, and a multi-cycle data-memory wait sequencer, so the core tolerates data memories with latency MEM_LAT.
- Also maintains saturating stall and flush performance counters.
- Sits beside the pipeline registers; its outputs drive the PC register, the F/D, D/E, E/M and M/W register enables and clears, and the SrcA/SrcB forwarding muxes.

Parameters:
- REG_AW, 5, register-address width.
- MEM_LAT, 2, data-memory wait cycles per access; 0 disables the wait sequencer.
- CNT_W, 16, performance-counter width.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-low reset.
- Rs1D, Rs2D  in  REG_AW  source registers of the instruction in D.
- Rs1E, Rs2E  in  REG_AW  source registers of the instruction in E.
- RdE, RdM, RdW  in  REG_AW  destination registers in E, M and W.
- RegWriteM, RegWriteW  in  1  register-write enables in M and W.
- ResultSrcE  in  2  result select in E; value 2'b01 marks a load.
- PCSrcE  in  1  branch/jump taken, resolved in E.
- MemValidM  in  1  instruction in M is a load or store (bubbles must drive 0).
- ForwardAE, ForwardBE  out  2  operand selects: 00 = register file, 01 = ResultW, 10 = ALUResultM.
- StallF, StallD, StallE, StallM, StallW  out  1  hold the corresponding stage register / PC.
- FlushD, FlushE  out  1  clear the F/D and D/E registers to a bubble.
- StallCycles  out  CNT_W  saturating count of memory-wait and load-use stall cycles.
- FlushCount  out  CNT_W  saturating count of cycles with FlushD asserted.

Behaviour:
- Reset: RST == 0 at a CLK edge sets the state to RUN, wait_cnt to 0 and both counters to 0. Outputs are combinational on state and inputs, so they are all 0 with idle inputs after reset. Reset mid-wait abandons the wait immediately.
- Forwarding, per operand X in {1, 2}:
  - select 10 if RegWriteM && RdM != 0 && RdM == RsXE;
  - else select 01 if RegWriteW && RdW != 0 && RdW == RsXE;
  - else select 00.
  - M has priority over W. Register x0 is never forwarded.
- Load-use: lwStall = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D). Response: StallF = StallD = 1, FlushE = 1. Exactly one bubble.
- Control hazard: PCSrcE gives FlushD = FlushE = 1.
  - Taken branch and lwStall together: the flush wins, StallF = StallD = 0. The D-stage instruction is wrong-path.
- Memory-wait FSM, states RUN, WAIT, RELEASE:
  - RUN: if MEM_LAT > 0 && MemValidM, then memStall = 1. Load wait_cnt = MEM_LAT-1. Go to WAIT, or to RELEASE if MEM_LAT == 1.
  - WAIT: memStall = 1. Decrement wait_cnt; at 0 go to RELEASE.
  - RELEASE: memStall = 0 and the pipeline advances for one cycle. MemValidM is ignored this cycle so the same access is never re-served. Then go to RUN.
  - Each access costs exactly MEM_LAT stall cycles. Back-to-back accesses see RUN on the cycle after RELEASE and stall again.
  - MEM_LAT == 0: FSM stays in RUN and memStall is always 0.
- memStall drives StallF, StallD, StallE, StallM and StallW all to 1 and forces FlushD = FlushE = 0.
  - lwStall and PCSrcE are masked during memStall and act after release.
  - Because W is held, the register file re-writes an identical value, which is idempotent.
  - Forwarding selects stay valid because M and W are frozen.
- Counters:
  - StallCycles increments on any cycle with memStall || (lwStall && !PCSrcE).
  - FlushCount increments on any cycle with FlushD.
  - Both saturate at all-ones and never wrap.
- No combinational path from StallX or FlushX back to any input.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - forward-select constants FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10;
  - the load result-source encoding RES_LOAD = 2'b01;
  - the FSM state encoding RUN, WAIT, RELEASE.
- One sub-module, hazard_fwd_sel: the combinational forward comparator for one operand, instantiated twice (A and B).
- The FSM and counters stay in pipe_hazard_ctrl.

Test Plan:
- Forwarding: RegWriteM = 1, RdM = 5, Rs1E = 5, RegWriteW = 1, RdW = 5 -> ForwardAE = 10. Same with RdM = 0 -> ForwardAE = 01. Rs2E = 0 with RdW = 0 -> ForwardBE = 00.
- Load-use: ResultSrcE = 01, RdE = 7, Rs2D = 7, PCSrcE = 0 -> StallF = StallD = FlushE = 1 for exactly one cycle, StallCycles += 1. Add PCSrcE = 1 -> StallF = 0, FlushD = FlushE = 1, FlushCount += 1.
- Memory wait, MEM_LAT = 2: MemValidM = 1 held -> all five stalls high for 2 cycles, low on the RELEASE cycle, high again for 2 cycles on the next access. StallCycles = 4 after two accesses.
- Masking: PCSrcE = 1 during WAIT -> FlushD = FlushE = 0 until the RELEASE cycle, then 1. FlushCount unchanged during the wait.
- Reset mid-wait: RST = 0 in WAIT -> next cycle state RUN, StallCycles = FlushCount = 0, all stalls 0 with idle inputs. MEM_LAT = 0 build: MemValidM = 1 -> never stalls.
- Saturation: CNT_W = 4, 20 consecutive memory-stall cycles -> StallCycles = 15 and holds.
